uart_ctrl: RTL and testbench

UART_CTRL -- requirements
Module: uart_ctrl

---
 rtl/uart_ctrl_pkg.sv | 35 +++
 rtl/uart_ctrl_if.sv | 26 ++
 rtl/uart_tx_fifo.sv | 54 +++++
 rtl/uart_ctrl.sv | 157 +++++++++++++++
 tb/tb_uart_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and register map for the UART control block: TX FSM states,
// register offsets (address bits [3:2]) and CTRL bit positions.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START     = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_e;

  localparam logic [1:0] REG_CTRL   = 2'b00;
  localparam logic [1:0] REG_RSVD   = 2'b01;
  localparam logic [1:0] REG_TXDATA = 2'b10;
  localparam logic [1:0] REG_RXDATA = 2'b11;

  localparam int CTRL_SEND   = 0;
  localparam int CTRL_NEW_RX = 1;
  localparam int CTRL_OVF    = 2;

  function automatic logic [31:0] ctrl_word(input logic send, input logic new_rx,
                                            input logic ovf);
    logic [31:0] w;
    w = '0;
    w[CTRL_SEND]   = send;
    w[CTRL_NEW_RX] = new_rx;
    w[CTRL_OVF]    = ovf;
    return w;
  endfunction

  function automatic logic [31:0] byte_word(input logic [7:0] b);
    return {24'h0, b};
  endfunction

endpackage

// File: rtl/uart_ctrl_if.sv
// Bundle of the CPU register bus and the UART core handshake. The master side is
// the environment (CPU decoder plus UART core); the slave side is uart_ctrl.
interface uart_ctrl_if;
  import uart_ctrl_pkg::*;

  logic        we_Uart;
  logic [31:0] Data_Address_o;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_valid;
  logic [7:0]  rx_data;

  modport master (
    output we_Uart, Data_Address_o, wdata, tx_busy, rx_valid, rx_data,
    input  rdata, tx_start, tx_data
  );

  modport slave (
    input  we_Uart, Data_Address_o, wdata, tx_busy, rx_valid, rx_data,
    output rdata, tx_start, tx_data
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO for queued TX bytes; DEPTH must be a power of two.
// Pushes when full and pops when empty are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped UART control/status registers (CTRL, TXDATA, RXDATA) with a TX handshake FSM.
// Define UART_CTRL_FIFO_EN to queue TX bytes in a FIFO_DEPTH-entry FIFO instead of the single SEND slot.
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  uart_ctrl_if.slave bus
);

  tx_state_e  state;
  tx_state_e  state_nxt;
  logic [1:0] reg_sel;
  logic       wr_ctrl;
  logic       wr_txdata;
  logic       tx_accept;
  logic       tx_drop;
  logic       pending;
  logic       load;
  logic       done;
  logic       tx_start;
  logic       send_bit;
  logic [7:0] tx_src;
  logic [7:0] tx_byte;
  logic [7:0] txdata_q;
  logic [7:0] rx_hold;
  logic       new_rx;
  logic       ovf;
  logic       unused_bits;

  assign reg_sel   = bus.Data_Address_o[3:2];
  assign wr_ctrl   = bus.we_Uart && (reg_sel == REG_CTRL);
  assign wr_txdata = bus.we_Uart && (reg_sel == REG_TXDATA);

  assign unused_bits = ^{bus.Data_Address_o[31:4], bus.Data_Address_o[1:0], bus.wdata[31:8]};

`ifdef UART_CTRL_FIFO_EN
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       unused_done;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .pop   (load),
    .din   (bus.wdata[7:0]),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_accept   = wr_txdata && !fifo_full;
  assign tx_drop     = wr_txdata && fifo_full;
  assign pending     = !fifo_empty;
  assign tx_src      = fifo_head;
  assign send_bit    = !fifo_empty || (state != TX_IDLE);
  assign unused_done = done;
`else
  logic                          send_q;
  logic [$clog2(FIFO_DEPTH):0]   unused_depth;

  assign unused_depth = '0;

  // A new SEND request in the completion cycle wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                send_q <= 1'b0;
    else if (wr_ctrl && bus.wdata[CTRL_SEND]) send_q <= 1'b1;
    else if (done)                          send_q <= 1'b0;
  end

  assign tx_accept = wr_txdata && !send_q;
  assign tx_drop   = wr_txdata && send_q;
  assign pending   = send_q;
  assign tx_src    = txdata_q;
  assign send_bit  = send_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            txdata_q <= '0;
    else if (tx_accept) txdata_q <= bus.wdata[7:0];
  end

  // A byte arriving in the same cycle as a CTRL clear keeps NEW_RX set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_hold <= '0;
      new_rx  <= 1'b0;
    end else if (bus.rx_valid) begin
      rx_hold <= bus.rx_data;
      new_rx  <= 1'b1;
    end else if (wr_ctrl && !bus.wdata[CTRL_NEW_RX]) begin
      new_rx  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    ovf <= 1'b0;
    else if (tx_drop)                           ovf <= 1'b1;
    else if (wr_ctrl && !bus.wdata[CTRL_OVF])   ovf <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)  state <= TX_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:      if (pending) state_nxt = TX_START;
      TX_START:     state_nxt = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (bus.tx_busy) state_nxt = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!bus.tx_busy) state_nxt = TX_IDLE;
      default:      state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_start = 1'b0;
    load     = 1'b0;
    done     = 1'b0;
    case (state)
      TX_IDLE:      load     = pending;
      TX_START:     tx_start = 1'b1;
      TX_WAIT_DONE: done     = !bus.tx_busy;
      default:      ;
    endcase
  end

  // tx_data is captured when leaving IDLE and held for the whole transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tx_byte <= '0;
    else if (load) tx_byte <= tx_src;
  end

  assign bus.tx_start = tx_start;
  assign bus.tx_data  = tx_byte;

  always_comb begin
    bus.rdata = '0;
    case (reg_sel)
      REG_CTRL:   bus.rdata = ctrl_word(send_bit, new_rx, ovf);
      REG_TXDATA: bus.rdata = byte_word(txdata_q);
      REG_RXDATA: bus.rdata = byte_word(rx_hold);
      REG_RSVD:   bus.rdata = '0;
      default:    bus.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl: stimulus pushes expected tx bytes and register
// reads into queues, a negedge monitor pops and compares. Honours UART_CTRL_FIFO_EN.
module tb_uart_ctrl;
  import uart_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_en = 1'b0;

  uart_ctrl_if bus ();

  uart_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int busy_len = 3;
  int reset_gen = 0;
  int start_cnt = 0;

  logic [7:0]  exp_tx[$];
  logic [31:0] exp_rd[$];
  logic [1:0]  exp_rd_reg[$];

  // Reference register state, updated from the register-map rules.
  logic       m_new_rx = 1'b0;
  logic       m_ovf = 1'b0;
  logic [7:0] m_rxhold = 8'h00;
  logic [7:0] m_txdata = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_ctrl(input logic send);
    return {29'd0, m_ovf, m_new_rx, send};
  endfunction

  function automatic string rname(input logic [1:0] r);
    case (r)
      2'b00:   return "rd_ctrl";
      2'b01:   return "rd_rsvd";
      2'b10:   return "rd_txdata";
      default: return "rd_rxdata";
    endcase
  endfunction

  // One bus cycle; upper address bits are randomised because only [3:2] decode.
  task automatic cyc(input logic we, input logic [1:0] a, input logic [31:0] wd,
                     input logic rd, input logic rxv, input logic [7:0] rxd);
    @(posedge clk);
    #1;
    bus.we_Uart        = we;
    bus.Data_Address_o = ($urandom() & 32'hFFFF_FFF3) | {28'h0, a, 2'b00};
    bus.wdata          = wd;
    rd_en              = rd;
    bus.rx_valid       = rxv;
    bus.rx_data        = rxd;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, REG_RSVD, $urandom(), 1'b0, 1'b0, 8'($urandom()));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b1, a, d, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    exp_rd.push_back(e);
    exp_rd_reg.push_back(a);
    cyc(1'b0, a, $urandom(), 1'b1, 1'b0, 8'h00);
  endtask

  task automatic rx(input logic [7:0] b);
    cyc(1'b0, REG_RSVD, 32'h0, 1'b0, 1'b1, b);
    m_rxhold = b;
    m_new_rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    wr(REG_TXDATA, ($urandom() & 32'hFFFF_FF00) | {24'h0, b});
`ifndef UART_CTRL_FIFO_EN
    wr(REG_CTRL, 32'h7);
`endif
    m_txdata = b;
    exp_tx.push_back(b);
    exp_done++;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done_cnt < exp_done && k < 400) begin
      idle(1);
      k++;
    end
    check("xfer_done_count", done_cnt, exp_done);
    idle(3);
  endtask

  task automatic wait_busy();
    int k;
    k = 0;
    while (k < 50) begin
      idle(1);
      @(negedge clk);
      if (bus.tx_busy === 1'b1) break;
      k++;
    end
    check("busy_seen", {31'd0, bus.tx_busy}, 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    reset_gen++;
    bus.we_Uart = 1'b0;
    bus.rx_valid = 1'b0;
    rd_en = 1'b0;
    bus.Data_Address_o = 32'h0;
    #2;
    check("rst_async_ctrl", bus.rdata, 32'h0);
    check("rst_async_tx_start", {31'd0, bus.tx_start}, 32'd0);
    check("rst_async_tx_data", {24'd0, bus.tx_data}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_new_rx = 1'b0;
    m_ovf = 1'b0;
    m_rxhold = 8'h00;
    m_txdata = 8'h00;
  endtask

  // Behavioural UART core: after tx_start, raise busy after a short delay and hold it.
  initial begin : core
    logic [7:0] b;
    int g;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        b = bus.tx_data;
        g = reset_gen;
        repeat (1 + $urandom_range(2)) @(posedge clk);
        #1 bus.tx_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1;
        if (g == reset_gen) check("tx_data_stable", {24'd0, bus.tx_data}, {24'd0, b});
        bus.tx_busy = 1'b0;
        done_cnt++;
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    logic [1:0]  r;
    if (bus.tx_start === 1'b1) begin
      start_cnt++;
      if (exp_tx.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL tx_start_unexpected: got pulse with tx_data 0x%0h, expected none at %0t",
                 bus.tx_data, $time);
      end else begin
        e = {24'd0, exp_tx.pop_front()};
        check("tx_data", {24'd0, bus.tx_data}, e);
      end
    end
    if (rd_en) begin
      if (exp_rd.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL rd_unexpected: got 0x%0h, expected no read", bus.rdata);
      end else begin
        r = exp_rd_reg.pop_front();
        e = exp_rd.pop_front();
        check(rname(r), bus.rdata, e);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] b;
    logic [7:0] x;
    logic [31:0] w;
    int op;
    int s0;
    bus.we_Uart = 1'b0;
    bus.Data_Address_o = 32'h0;
    bus.wdata = 32'h0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check("rst_ctrl", bus.rdata, 32'd0);
    rst = 1'b0;
    idle(2);
    rd(REG_CTRL, 32'h0);
    rd(REG_TXDATA, 32'h0);
    rd(REG_RXDATA, 32'h0);
    idle(6);

    // Single byte, 10-cycle busy.
    busy_len = 10;
    wr(REG_TXDATA, 32'h0000_0055);
    wr(REG_CTRL, 32'h1);
    m_txdata = 8'h55;
    exp_tx.push_back(8'h55);
    exp_done++;
    rd(REG_CTRL, exp_ctrl(1'b1));
    wait_done();
    rd(REG_CTRL, 32'h0);
    rd(REG_TXDATA, 32'h55);

    // Receive path and NEW_RX clear.
    rx(8'hA3);
    rd(REG_RXDATA, 32'hA3);
    rd(REG_CTRL, exp_ctrl(1'b0));
    wr(REG_RXDATA, 32'hFFFF_FFFF);
    rd(REG_RXDATA, 32'hA3);
    wr(REG_CTRL, 32'h0);
    m_new_rx = 1'b0;
    rd(REG_CTRL, 32'h0);

    // Incoming byte beats a simultaneous clear.
    cyc(1'b1, REG_CTRL, 32'h0, 1'b0, 1'b1, 8'h3C);
    m_rxhold = 8'h3C;
    m_new_rx = 1'b1;
    rd(REG_CTRL, 32'h2);
    rd(REG_RXDATA, 32'h3C);

    // Reserved register writes/reads.
    wr(REG_RSVD, 32'hFFFF_FFFF);
    rd(REG_RSVD, 32'h0);
    rd(REG_CTRL, exp_ctrl(1'b0));
    rd(REG_TXDATA, 32'h55);
    wr(REG_CTRL, 32'h0);
    m_new_rx = 1'b0;

`ifdef UART_CTRL_FIFO_EN
    // Five pushes while the core is busy: four fit, the fifth sets OVF.
    busy_len = 14;
    send_byte(8'hEE);
    wait_busy();
    for (int i = 1; i <= 5; i++) wr(REG_TXDATA, i);
    for (int i = 1; i <= 4; i++) exp_tx.push_back(8'(i));
    exp_done += 4;
    m_txdata = 8'h04;
    m_ovf = 1'b1;
    rd(REG_CTRL, exp_ctrl(1'b1));
    wait_done();
    rd(REG_CTRL, 32'h4);
    wr(REG_CTRL, 32'h0);
    m_ovf = 1'b0;
    rd(REG_CTRL, 32'h0);
    busy_len = 3;
    send_byte(8'($urandom()));
    wait_done();
`else
    // Write to TXDATA while SEND is set is dropped and flags OVF.
    busy_len = 8;
    b = 8'($urandom());
    send_byte(b);
    wr(REG_TXDATA, 32'h11);
    m_ovf = 1'b1;
    wait_done();
    rd(REG_CTRL, 32'h4);
    rd(REG_TXDATA, {24'd0, b});
    wr(REG_CTRL, 32'h4);
    rd(REG_CTRL, 32'h4);
    wr(REG_CTRL, 32'h0);
    m_ovf = 1'b0;
    rd(REG_CTRL, 32'h0);
`endif

    // Randomised mix of sends, receives and CTRL writes.
    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(3);
      busy_len = 2 + $urandom_range(6);
      case (op)
        0, 1: begin
          b = 8'($urandom());
          send_byte(b);
          rd(REG_CTRL, exp_ctrl(1'b1));
          if ($urandom_range(1) == 1) begin
            x = 8'($urandom());
            wr(REG_TXDATA, {24'd0, x});
`ifdef UART_CTRL_FIFO_EN
            m_txdata = x;
            exp_tx.push_back(x);
            exp_done++;
`else
            m_ovf = 1'b1;
`endif
          end
          wait_done();
        end
        2: begin
          b = 8'($urandom());
          w = $urandom() & 32'hFFFF_FFFE;
          if ($urandom_range(1) == 1) begin
            cyc(1'b1, REG_CTRL, w, 1'b0, 1'b1, b);
            if (!w[2]) m_ovf = 1'b0;
            m_rxhold = b;
            m_new_rx = 1'b1;
          end else begin
            rx(b);
          end
        end
        default: begin
          w = $urandom();
          wr(REG_CTRL, w);
          if (!w[1]) m_new_rx = 1'b0;
          if (!w[2]) m_ovf = 1'b0;
`ifndef UART_CTRL_FIFO_EN
          if (w[0]) begin
            exp_tx.push_back(m_txdata);
            exp_done++;
            wait_done();
          end
`endif
        end
      endcase
      rd(REG_CTRL, exp_ctrl(1'b0));
      rd(REG_TXDATA, {24'd0, m_txdata});
      rd(REG_RXDATA, {24'd0, m_rxhold});
    end

    // Reset while the FSM waits for the core to finish.
    busy_len = 16;
    send_byte(8'($urandom()));
    wait_busy();
    idle(2);
`ifdef UART_CTRL_FIFO_EN
    wr(REG_TXDATA, 32'h77);
    wr(REG_TXDATA, 32'h88);
`endif
    pulse_reset();
    rd(REG_CTRL, 32'h0);
    rd(REG_TXDATA, 32'h0);
    rd(REG_RXDATA, 32'h0);
    s0 = start_cnt;
    idle(30);
    check("no_start_after_rst", start_cnt, s0);
    wait_done();

    idle(5);
    check("tx_queue_drained", exp_tx.size(), 32'd0);
    check("rd_queue_drained", exp_rd.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
